// File: rtl/thermal_pkg.sv
// thermal_pkg: state encoding and sample classification shared by the thermal monitor.
package thermal_pkg;
  typedef enum logic [1:0] {NORMAL, WARN, OVERHEATED, COOLING} state_t;
  typedef struct packed {
    logic hot;
    logic cool;
  } class_t;
  function automatic class_t classify(input int unsigned t, input int unsigned hot_th,
                                      input int unsigned cool_th);
    class_t c;
    c.hot  = t >= hot_th;
    c.cool = t < cool_th;
    return c;
  endfunction
endpackage

// File: rtl/thermal_stats.sv
// thermal_stats: peak sample tracker and saturating trip counter for the thermal monitor.
module thermal_stats #(
  parameter int unsigned TEMP_W = 8,
  parameter int unsigned EVT_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp,
  input  logic              trip,
  output logic [TEMP_W-1:0] peak_temp,
  output logic [EVT_W-1:0]  trip_count
);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      peak_temp  <= '0;
      trip_count <= '0;
    end else begin
      if (temp_valid && temp > peak_temp) peak_temp <= temp;
      if (trip && trip_count != '1) trip_count <= trip_count + 1'b1;
    end
endmodule

// File: rtl/cpu_thermal_monitor.sv
// cpu_thermal_monitor: hysteresis + debounce on raw temperature samples producing cpu_overheated.
// Optional THERMAL_STATS_EN adds peak_temp and trip_count.
module cpu_thermal_monitor
  import thermal_pkg::*;
#(
  parameter int unsigned TEMP_W      = 8,
  parameter int unsigned HOT_THRESH  = 95,
  parameter int unsigned COOL_THRESH = 80,
  parameter int unsigned HOT_CNT     = 4,
  parameter int unsigned COOL_CNT    = 8
`ifdef THERMAL_STATS_EN
  , parameter int unsigned EVT_W     = 8
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp,
  output logic              cpu_overheated,
  output logic              warn,
  output logic              trip_pulse,
  output logic              clear_pulse
`ifdef THERMAL_STATS_EN
  , output logic [TEMP_W-1:0] peak_temp,
  output logic [EVT_W-1:0]  trip_count
`endif
);
  localparam int unsigned CNT_MAX = HOT_CNT > COOL_CNT ? HOT_CNT : COOL_CNT;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOT_T  = CW'(HOT_CNT);
  localparam logic [CW-1:0] COOL_T = CW'(COOL_CNT);
  localparam logic [CW-1:0] ONE    = CW'(1);
  state_t state, nxt;
  logic [CW-1:0] cnt, nxt_cnt, cnt_inc;
  class_t c;
  logic trip, clear;
  assign c       = classify(32'(temp), HOT_THRESH, COOL_THRESH);
  assign cnt_inc = cnt + ONE;
  // Invalid cycles leave nxt == state, so pulses below need no temp_valid term.
  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    if (temp_valid)
      case (state)
        NORMAL: if (c.hot) begin
          nxt     = (HOT_T == ONE) ? OVERHEATED : WARN;
          nxt_cnt = (HOT_T == ONE) ? '0 : ONE;
        end
        WARN: begin
          nxt     = !c.hot ? NORMAL : (cnt_inc == HOT_T) ? OVERHEATED : WARN;
          nxt_cnt = (!c.hot || cnt_inc == HOT_T) ? '0 : cnt_inc;
        end
        OVERHEATED: if (c.cool) begin
          nxt     = (COOL_T == ONE) ? NORMAL : COOLING;
          nxt_cnt = (COOL_T == ONE) ? '0 : ONE;
        end
        COOLING: begin
          nxt     = !c.cool ? OVERHEATED : (cnt_inc == COOL_T) ? NORMAL : COOLING;
          nxt_cnt = (!c.cool || cnt_inc == COOL_T) ? '0 : cnt_inc;
        end
        default: ;
      endcase
  end
  assign trip  = nxt == OVERHEATED && (state == NORMAL || state == WARN);
  assign clear = nxt == NORMAL && (state == OVERHEATED || state == COOLING);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state          <= NORMAL;
      cnt            <= '0;
      cpu_overheated <= 1'b0;
      warn           <= 1'b0;
      trip_pulse     <= 1'b0;
      clear_pulse    <= 1'b0;
    end else begin
      state          <= nxt;
      cnt            <= nxt_cnt;
      cpu_overheated <= nxt == OVERHEATED || nxt == COOLING;
      warn           <= nxt == WARN;
      trip_pulse     <= trip;
      clear_pulse    <= clear;
    end
`ifdef THERMAL_STATS_EN
  thermal_stats #(.TEMP_W(TEMP_W), .EVT_W(EVT_W)) u_stats (
    .clk        (clk),
    .resetn     (resetn),
    .temp_valid (temp_valid),
    .temp       (temp),
    .trip       (trip),
    .peak_temp  (peak_temp),
    .trip_count (trip_count)
  );
`endif
endmodule
